// File: rtl/sample_feeder_if.sv
// Handshake and filter-stage signals of sample_feeder. The master side is the upstream
// source, downstream sink and external filter; the slave side is the feeder itself.
interface sample_feeder_if;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] w_prev;
    logic [31:0] y;
    logic [31:0] w_in;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [15:0] sample_cnt;

    modport master (
        output flush, in_valid, in_data, y, w_in, out_ready,
        input  in_ready, x, w_prev, out_valid, out_data, sample_cnt
    );

    modport slave (
        input  flush, in_valid, in_data, y, w_in, out_ready,
        output in_ready, x, w_prev, out_valid, out_data, sample_cnt
    );
endinterface

// File: rtl/sample_feeder.sv
// Buffers 32-bit samples in a FIFO and presents each one to an external combinational filter.
// The filter result and state are captured after a fixed settle time.
module sample_feeder #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned SETTLE = 4,
    parameter logic [31:0] W_INIT = 32'd10
) (
    input logic            clk,
    input logic            rst,
    sample_feeder_if.slave io_bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {StIdle, StSettle, StEmit} state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_settle_cnt;
    logic [31:0]   r_x;
    logic [31:0]   r_w_prev;
    logic [31:0]   r_out_data;
    logic [15:0]   r_sample_cnt;

    logic w_in_ready;
    logic w_push;
    logic w_pop;
    logic w_settle_done;
    logic w_capture;
    logic w_accept;
    logic w_out_valid;

    // in_ready depends on count only, so a pop on a full FIFO never opens a push slot.
    assign w_in_ready    = (r_count < CW'(DEPTH));
    assign w_push        = io_bus.in_valid && w_in_ready && !io_bus.flush;
    assign w_settle_done = (r_settle_cnt == SW'(SETTLE - 1));

    always_ff @(posedge clk) begin
        if (rst || io_bus.flush) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (r_count != '0) w_state_next = StSettle;
            StSettle: if (w_settle_done) w_state_next = StEmit;
            StEmit:   if (io_bus.out_ready) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            StIdle:   w_pop = (r_count != '0);
            StSettle: w_capture = w_settle_done;
            StEmit: begin
                w_out_valid = 1'b1;
                w_accept    = io_bus.out_ready;
            end
            default: ;
        endcase
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= io_bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_settle_cnt <= '0;
            r_x          <= '0;
            r_w_prev     <= W_INIT;
            r_out_data   <= '0;
            r_sample_cnt <= '0;
        end else if (io_bus.flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_settle_cnt <= '0;
            r_w_prev     <= W_INIT;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_x          <= r_mem[r_rd_ptr];
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_settle_cnt <= '0;
            end else if (r_state == StSettle) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end
            if (w_capture) begin
                r_out_data <= io_bus.y;
                r_w_prev   <= io_bus.w_in;
            end
            if (w_accept) begin
                r_sample_cnt <= r_sample_cnt + 16'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign io_bus.in_ready   = w_in_ready;
    assign io_bus.x          = r_x;
    assign io_bus.w_prev     = r_w_prev;
    assign io_bus.out_valid  = w_out_valid;
    assign io_bus.out_data   = r_out_data;
    assign io_bus.sample_cnt = r_sample_cnt;
endmodule

// File: tb/tb_sample_feeder.sv
// Randomised self-checking bench for sample_feeder: a queue-based model of the feeder is
// compared against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_sample_feeder;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned SETTLE = 4;
    localparam logic [31:0] W_INIT = 32'd10;

    logic clk;
    logic rst;
    int   mode;
    int   n_checks;
    int   n_pass;
    bit   chk_en;

    sample_feeder_if bus ();

    sample_feeder #(
        .DEPTH (DEPTH),
        .SETTLE(SETTLE),
        .W_INIT(W_INIT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External filter: mode 0 is the simple y=x+1 / w=x+2 stage, mode 1 mixes in the state.
    function automatic logic [31:0] fy(input int md, input logic [31:0] xv, input logic [31:0] wp);
        return (md == 0) ? xv + 32'd1 : xv * 32'd3 + wp;
    endfunction

    function automatic logic [31:0] fw(input int md, input logic [31:0] xv, input logic [31:0] wp);
        return (md == 0) ? xv + 32'd2 : xv ^ wp ^ 32'h1234_5678;
    endfunction

    always_comb begin
        bus.y    = fy(mode, bus.x, bus.w_prev);
        bus.w_in = fw(mode, bus.x, bus.w_prev);
    end

    // Model: queue of stored samples; m_phase -1 = waiting, 0..SETTLE-1 = settling, SETTLE = emitting.
    logic [31:0] mq[$];
    int          m_phase;
    logic [31:0] m_x;
    logic [31:0] m_wp;
    logic [31:0] m_od;
    logic [15:0] m_sc;
    int          m_pushes;
    int          m_emits;

    task automatic model_step();
        int sz;
        bit do_push;
        logic [31:0] ny;
        logic [31:0] nw;
        sz      = mq.size();
        do_push = bus.in_valid && (sz < DEPTH);
        if (rst) begin
            mq.delete();
            m_phase = -1;
            m_x     = '0;
            m_wp    = W_INIT;
            m_od    = '0;
            m_sc    = '0;
        end else if (bus.flush) begin
            mq.delete();
            m_phase = -1;
            m_wp    = W_INIT;
        end else begin
            if (m_phase < 0) begin
                if (sz > 0) begin
                    m_x     = mq.pop_front();
                    m_phase = 0;
                end
            end else if (m_phase < int'(SETTLE)) begin
                if (m_phase == int'(SETTLE) - 1) begin
                    ny      = fy(mode, m_x, m_wp);
                    nw      = fw(mode, m_x, m_wp);
                    m_od    = ny;
                    m_wp    = nw;
                    m_phase = SETTLE;
                end else begin
                    m_phase++;
                end
            end else if (bus.out_ready) begin
                m_sc    = m_sc + 16'd1;
                m_phase = -1;
                m_emits++;
            end
            if (do_push) begin
                mq.push_back(bus.in_data);
                m_pushes++;
            end
        end
    endtask

    initial begin
        m_phase  = -1;
        m_pushes = 0;
        m_emits  = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
            chk("out_valid", 32'(bus.out_valid), 32'(m_phase == int'(SETTLE)));
            chk("x", bus.x, m_x);
            chk("w_prev", bus.w_prev, m_wp);
            chk("out_data", bus.out_data, m_od);
            chk("sample_cnt", 32'(bus.sample_cnt), 32'(m_sc));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        int i;
        i = 0;
        while (!bus.out_valid && i < limit) begin
            step();
            i++;
        end
        chk("wait_out_valid", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic drain(input int limit);
        int i;
        i = 0;
        while ((mq.size() != 0 || m_phase != -1) && i < limit) begin
            step();
            i++;
        end
        chk("drain_done", 32'(mq.size() == 0 && m_phase == -1), 32'd1);
    endtask

    task automatic push_one(input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int base_push;
        int base_emit;
        n_checks      = 0;
        n_pass        = 0;
        chk_en        = 1'b0;
        mode          = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        do_reset();
        chk_en = 1'b1;

        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_x", bus.x, 32'd0);
        chk("rst_w_prev", bus.w_prev, 32'd10);
        chk("rst_sample_cnt", 32'(bus.sample_cnt), 32'd0);

        // Single sample: push at E0, out_valid only after E5.
        push_one(32'h0000_0005);
        repeat (4) step();
        chk("single_not_yet_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_out_data", bus.out_data, 32'd6);
        chk("single_w_prev", bus.w_prev, 32'd7);
        bus.out_ready = 1'b1;
        step();
        chk("single_sample_cnt", 32'(bus.sample_cnt), 32'd1);
        chk("single_valid_drop", 32'(bus.out_valid), 32'd0);

        // Fill under backpressure: first pop at E1, full after E8, 9 samples accepted.
        mode          = 1;
        bus.out_ready = 1'b0;
        base_push     = m_pushes;
        base_emit     = m_emits;
        bus.in_valid  = 1'b1;
        for (int j = 0; j < 12; j++) begin
            bus.in_data = $urandom;
            step();
            chk("fill_in_ready", 32'(bus.in_ready), 32'(j < 8));
        end
        bus.in_valid = 1'b0;
        chk("fill_accepted", 32'(m_pushes - base_push), 32'd9);
        repeat (13) step();
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_still_full", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        drain(200);
        chk("fill_emitted", 32'(m_emits - base_emit), 32'd9);
        chk("fill_sample_cnt", 32'(bus.sample_cnt), 32'd10);

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.in_data   = $urandom;
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 99) == 0);
            rst           = ($urandom_range(0, 299) == 0);
            step();
        end
        bus.flush = 1'b0;
        do_reset();

        // Flush mid-settle with three samples queued.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int j = 0; j < 4; j++) begin
            bus.in_data = 32'h100 + 32'(j);
            step();
        end
        bus.in_valid = 1'b0;
        chk("pre_flush_queued", 32'(mq.size()), 32'd3);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_w_prev", bus.w_prev, 32'd10);
        chk("flush_x_kept", bus.x, 32'h100);
        repeat (10) step();
        chk("flush_no_emit", 32'(bus.sample_cnt), 32'd0);

        // Reset while in EMIT with out_ready=1 on the same edge.
        push_one(32'h0000_0042);
        wait_valid(20);
        step();
        push_one(32'h0000_0077);
        bus.out_ready = 1'b0;
        wait_valid(20);
        chk("pre_rst_sample_cnt", 32'(bus.sample_cnt), 32'd1);
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_emit_sample_cnt", 32'(bus.sample_cnt), 32'd0);
        chk("rst_emit_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_emit_out_data", bus.out_data, 32'd0);
        chk("rst_emit_x", bus.x, 32'd0);
        chk("rst_emit_w_prev", bus.w_prev, 32'd10);
        chk("rst_emit_in_ready", 32'(bus.in_ready), 32'd1);

        // Sample counter wrap from 16'hFFFF.
        force dut.r_sample_cnt = 16'hFFFF;
        m_sc = 16'hFFFF;
        step();
        release dut.r_sample_cnt;
        step();
        chk("wrap_preload", 32'(bus.sample_cnt), 32'h0000_FFFF);
        push_one($urandom);
        wait_valid(20);
        step();
        chk("wrap_sample_cnt", 32'(bus.sample_cnt), 32'd0);
        repeat (3) step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
